// File: rtl/alu_share_arbiter.sv
// alu_share_arbiter
// Time-shares one combinational ALU between two requesters. Requester 0 is the
// execute path and requester 1 is an auxiliary unit. Grants are round-robin.
// Each operation walks IDLE -> EXEC -> RESP. Operands are registered before
// they reach the ALU, and the ALU result is registered before it is returned.
// When nothing is in flight, the ALU inputs are held at PARK_OP with zero
// operands. This keeps the ALU's unknown-opcode abort path quiet.

module alu_share_arbiter #(
    parameter int              DATA_W  = 32,
    parameter int              OP_W    = 4,
    parameter logic [OP_W-1:0] PARK_OP = 4'b0000
) (
    input  logic              clk,
    input  logic              rst_n,

    // requester 0 (execute path)
    input  logic              req0_valid,
    output logic              req0_ready,
    input  logic [OP_W-1:0]   req0_op,
    input  logic [DATA_W-1:0] req0_a,
    input  logic [DATA_W-1:0] req0_b,
    output logic              resp0_valid,
    input  logic              resp0_ready,
    output logic [DATA_W-1:0] resp0_result,
    output logic              resp0_zero,
    output logic              resp0_less,

    // requester 1 (auxiliary unit)
    input  logic              req1_valid,
    output logic              req1_ready,
    input  logic [OP_W-1:0]   req1_op,
    input  logic [DATA_W-1:0] req1_a,
    input  logic [DATA_W-1:0] req1_b,
    output logic              resp1_valid,
    input  logic              resp1_ready,
    output logic [DATA_W-1:0] resp1_result,
    output logic              resp1_zero,
    output logic              resp1_less,

    // shared ALU
    output logic [OP_W-1:0]   alu_op,
    output logic [DATA_W-1:0] alu_a,
    output logic [DATA_W-1:0] alu_b,
    input  logic [DATA_W-1:0] alu_result,
    input  logic              alu_zero,
    input  logic              alu_less,

    output logic              busy
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_EXEC = 2'b01,
        ST_RESP = 2'b10
    } state_t;

    state_t              state_r;
    state_t              state_s;

    // Requester that was served last. Ties go to the other side.
    logic                last_grant_r;
    // Requester whose operation is currently in flight.
    logic                owner_r;

    logic                grant_valid_s;
    logic                grant_sel_s;
    logic                req_hs_s;
    logic                resp_hs_s;

    logic [OP_W-1:0]     sel_op_s;
    logic [DATA_W-1:0]   sel_a_s;
    logic [DATA_W-1:0]   sel_b_s;

    logic [OP_W-1:0]     op_r;
    logic [DATA_W-1:0]   a_r;
    logic [DATA_W-1:0]   b_r;

    logic [DATA_W-1:0]   result_r;
    logic                zero_r;
    logic                less_r;

    logic                resp0_valid_r;
    logic                resp1_valid_r;
    logic                busy_r;
    logic                resp0_valid_s;
    logic                resp1_valid_s;
    logic                busy_s;

    // Round-robin grant selection: a lone requester wins; on a tie the side not served last wins
    always_comb begin
        grant_valid_s = 1'b0;
        grant_sel_s   = 1'b0;
        if (req0_valid && req1_valid) begin
            grant_valid_s = 1'b1;
            grant_sel_s   = ~last_grant_r;
        end else if (req0_valid) begin
            grant_valid_s = 1'b1;
            grant_sel_s   = 1'b0;
        end else if (req1_valid) begin
            grant_valid_s = 1'b1;
            grant_sel_s   = 1'b1;
        end else begin
            grant_valid_s = 1'b0;
            grant_sel_s   = 1'b0;
        end
    end

    // Ready is combinational from valid and last_grant. It is gated by rst_n so that it stays low during reset.
    assign req0_ready = rst_n & (state_r == ST_IDLE) & grant_valid_s & ~grant_sel_s;
    assign req1_ready = rst_n & (state_r == ST_IDLE) & grant_valid_s &  grant_sel_s;

    assign req_hs_s  = (req0_valid & req0_ready) | (req1_valid & req1_ready);
    assign resp_hs_s = (state_r == ST_RESP) & (owner_r ? resp1_ready : resp0_ready);

    // Payload multiplexer feeding the operand registers from the granted side
    always_comb begin
        sel_op_s = req0_op;
        sel_a_s  = req0_a;
        sel_b_s  = req0_b;
        if (grant_sel_s) begin
            sel_op_s = req1_op;
            sel_a_s  = req1_a;
            sel_b_s  = req1_b;
        end else begin
            sel_op_s = req0_op;
            sel_a_s  = req0_a;
            sel_b_s  = req0_b;
        end
    end

    // Next-state logic plus next values of the registered status outputs
    always_comb begin
        state_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (req_hs_s) begin
                    state_s = ST_EXEC;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_EXEC: begin
                state_s = ST_RESP;
            end
            ST_RESP: begin
                if (resp_hs_s) begin
                    state_s = ST_IDLE;
                end else begin
                    state_s = ST_RESP;
                end
            end
            default: begin
                state_s = ST_IDLE;
            end
        endcase
        // owner_r only changes in IDLE, so it already names the right side whenever the next state is RESP
        resp0_valid_s = (state_s == ST_RESP) & ~owner_r;
        resp1_valid_s = (state_s == ST_RESP) &  owner_r;
        busy_s        = (state_s != ST_IDLE);
    end

    // State, ownership and round-robin history registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r      <= ST_IDLE;
            last_grant_r <= 1'b1;
            owner_r      <= 1'b0;
        end else begin
            state_r <= state_s;
            if (req_hs_s) begin
                owner_r <= grant_sel_s;
            end
            if (resp_hs_s) begin
                last_grant_r <= owner_r;
            end
        end
    end

    // Operand registers: capture on accept, park again once the response is consumed
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_r <= PARK_OP;
            a_r  <= {DATA_W{1'b0}};
            b_r  <= {DATA_W{1'b0}};
        end else if (req_hs_s) begin
            op_r <= sel_op_s;
            a_r  <= sel_a_s;
            b_r  <= sel_b_s;
        end else if (resp_hs_s) begin
            op_r <= PARK_OP;
            a_r  <= {DATA_W{1'b0}};
            b_r  <= {DATA_W{1'b0}};
        end
    end

    // Response registers: sample the ALU at the end of EXEC and hold the values through RESP
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            result_r <= {DATA_W{1'b0}};
            zero_r   <= 1'b0;
            less_r   <= 1'b0;
        end else if (state_r == ST_EXEC) begin
            result_r <= alu_result;
            zero_r   <= alu_zero;
            less_r   <= alu_less;
        end
    end

    // Registered response-valid and busy flags. The async reset drops them immediately.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            resp0_valid_r <= 1'b0;
            resp1_valid_r <= 1'b0;
            busy_r        <= 1'b0;
        end else begin
            resp0_valid_r <= resp0_valid_s;
            resp1_valid_r <= resp1_valid_s;
            busy_r        <= busy_s;
        end
    end

    assign alu_op       = op_r;
    assign alu_a        = a_r;
    assign alu_b        = b_r;

    assign resp0_valid  = resp0_valid_r;
    assign resp0_result = result_r;
    assign resp0_zero   = zero_r;
    assign resp0_less   = less_r;

    assign resp1_valid  = resp1_valid_r;
    assign resp1_result = result_r;
    assign resp1_zero   = zero_r;
    assign resp1_less   = less_r;

    assign busy         = busy_r;

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Self-checking bench for alu_share_arbiter. A small combinational ALU model
// stands in for the shared ALU, using the encoding ADD=0 SUB=1 AND=2 OR=3
// XOR=4 SLL=5 SRL=6 SRA=7 SLT=8 SLTU=9. Any other opcode counts as an abort.

module tb_alu_share_arbiter;

    localparam logic [3:0] OP_ADD  = 4'd0;
    localparam logic [3:0] OP_SUB  = 4'd1;
    localparam logic [3:0] OP_AND  = 4'd2;
    localparam logic [3:0] OP_OR   = 4'd3;
    localparam logic [3:0] OP_XOR  = 4'd4;
    localparam logic [3:0] OP_SLL  = 4'd5;
    localparam logic [3:0] OP_SRL  = 4'd6;
    localparam logic [3:0] OP_SRA  = 4'd7;
    localparam logic [3:0] OP_SLT  = 4'd8;
    localparam logic [3:0] OP_SLTU = 4'd9;

    logic        clk;
    logic        rst_n;
    logic        req0_valid, req0_ready, resp0_valid, resp0_ready, resp0_zero, resp0_less;
    logic        req1_valid, req1_ready, resp1_valid, resp1_ready, resp1_zero, resp1_less;
    logic [3:0]  req0_op, req1_op, alu_op;
    logic [31:0] req0_a, req0_b, req1_a, req1_b, resp0_result, resp1_result;
    logic [31:0] alu_a, alu_b, alu_result;
    logic        alu_zero, alu_less, busy;

    int n_cmp;
    int n_fail;
    int abort_cnt;

    alu_share_arbiter #(.DATA_W(32), .OP_W(4), .PARK_OP(4'b0000)) dut (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_op(req0_op),
        .req0_a(req0_a), .req0_b(req0_b),
        .resp0_valid(resp0_valid), .resp0_ready(resp0_ready), .resp0_result(resp0_result),
        .resp0_zero(resp0_zero), .resp0_less(resp0_less),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_op(req1_op),
        .req1_a(req1_a), .req1_b(req1_b),
        .resp1_valid(resp1_valid), .resp1_ready(resp1_ready), .resp1_result(resp1_result),
        .resp1_zero(resp1_zero), .resp1_less(resp1_less),
        .alu_op(alu_op), .alu_a(alu_a), .alu_b(alu_b),
        .alu_result(alu_result), .alu_zero(alu_zero), .alu_less(alu_less),
        .busy(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // combinational ALU model
    always_comb begin
        alu_result = 32'd0;
        case (alu_op)
            OP_ADD:  alu_result = alu_a + alu_b;
            OP_SUB:  alu_result = alu_a - alu_b;
            OP_AND:  alu_result = alu_a & alu_b;
            OP_OR:   alu_result = alu_a | alu_b;
            OP_XOR:  alu_result = alu_a ^ alu_b;
            OP_SLL:  alu_result = alu_a << alu_b[4:0];
            OP_SRL:  alu_result = alu_a >> alu_b[4:0];
            OP_SRA:  alu_result = $unsigned($signed(alu_a) >>> alu_b[4:0]);
            OP_SLT:  alu_result = {31'd0, ($signed(alu_a) < $signed(alu_b))};
            OP_SLTU: alu_result = {31'd0, (alu_a < alu_b)};
            default: alu_result = 32'd0;
        endcase
        alu_zero = (alu_result == 32'd0);
        alu_less = (alu_op == OP_SLTU) ? (alu_a < alu_b) : ($signed(alu_a) < $signed(alu_b));
    end

    // unknown opcode at the ALU would trigger its abort path
    always @(posedge clk) begin
        if (rst_n && (alu_op > OP_SLTU)) abort_cnt++;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        logic        side;
        logic [3:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] res;
        logic        z;
        logic        l;
    } vec_t;

    vec_t vecs[8];

    // one uncontended transaction on `side`, checked cycle by cycle
    task automatic run_txn(input vec_t v, input int idx);
        string t;
        t = $sformatf("v%0d", idx);
        if (v.side) begin
            req1_valid = 1'b1; req1_op = v.op; req1_a = v.a; req1_b = v.b; resp1_ready = 1'b1;
        end else begin
            req0_valid = 1'b1; req0_op = v.op; req0_a = v.a; req0_b = v.b; resp0_ready = 1'b1;
        end
        @(negedge clk);
        chk({t, "_ready"},     v.side ? req1_ready : req0_ready, 32'd1);
        chk({t, "_oth_ready"}, v.side ? req0_ready : req1_ready, 32'd0);
        chk({t, "_park_op"},   alu_op, 32'd0);
        chk({t, "_park_a"},    alu_a,  32'd0);
        step();
        req0_valid = 1'b0; req1_valid = 1'b0;
        @(negedge clk);
        chk({t, "_exec_busy"}, busy,   32'd1);
        chk({t, "_exec_op"},   alu_op, {28'd0, v.op});
        chk({t, "_exec_a"},    alu_a,  v.a);
        chk({t, "_exec_b"},    alu_b,  v.b);
        chk({t, "_exec_rv"},   {resp1_valid, resp0_valid}, 32'd0);
        step();
        @(negedge clk);
        chk({t, "_rv"},     v.side ? resp1_valid : resp0_valid, 32'd1);
        chk({t, "_oth_rv"}, v.side ? resp0_valid : resp1_valid, 32'd0);
        chk({t, "_res"},    v.side ? resp1_result : resp0_result, v.res);
        chk({t, "_zero"},   v.side ? resp1_zero : resp0_zero, {31'd0, v.z});
        chk({t, "_less"},   v.side ? resp1_less : resp0_less, {31'd0, v.l});
        step();
        resp0_ready = 1'b0; resp1_ready = 1'b0;
        @(negedge clk);
        chk({t, "_done_busy"}, busy, 32'd0);
        chk({t, "_done_rv"},   {resp1_valid, resp0_valid}, 32'd0);
        chk({t, "_done_op"},   alu_op, 32'd0);
        chk({t, "_done_b"},    alu_b,  32'd0);
        step();
    endtask

    initial begin
        n_cmp = 0; n_fail = 0; abort_cnt = 0;
        vecs[0] = '{1'b0, OP_SUB,  32'd5,          32'd7,          32'hFFFF_FFFE, 1'b0, 1'b1};
        vecs[1] = '{1'b1, OP_SLTU, 32'hFFFF_FFFF,  32'd1,          32'd0,         1'b1, 1'b0};
        vecs[2] = '{1'b0, OP_AND,  32'hF0F0_F0F0,  32'h0FF0_0FF0,  32'h00F0_00F0, 1'b0, 1'b1};
        vecs[3] = '{1'b1, OP_SLL,  32'd1,          32'd4,          32'd16,        1'b0, 1'b1};
        vecs[4] = '{1'b0, OP_SRA,  32'h8000_0000,  32'd4,          32'hF800_0000, 1'b0, 1'b1};
        vecs[5] = '{1'b1, OP_SLT,  32'hFFFF_FFFF,  32'd1,          32'd1,         1'b0, 1'b1};
        vecs[6] = '{1'b0, OP_ADD,  32'hFFFF_FFFF,  32'd1,          32'd0,         1'b1, 1'b1};
        vecs[7] = '{1'b1, OP_OR,   32'd0,          32'd0,          32'd0,         1'b1, 1'b0};

        rst_n = 1'b0;
        req0_valid = 1'b1; req0_op = OP_ADD; req0_a = 32'd0; req0_b = 32'd0; resp0_ready = 1'b0;
        req1_valid = 1'b0; req1_op = OP_ADD; req1_a = 32'd0; req1_b = 32'd0; resp1_ready = 1'b0;
        step();
        step();
        // reset state, with a request pending to prove ready is forced low
        chk("rst_req0_ready", req0_ready, 32'd0);
        chk("rst_busy",  busy, 32'd0);
        chk("rst_rv",    {resp1_valid, resp0_valid}, 32'd0);
        chk("rst_op",    alu_op, 32'd0);
        chk("rst_a",     alu_a, 32'd0);
        chk("rst_b",     alu_b, 32'd0);
        chk("rst_res",   resp0_result, 32'd0);
        chk("rst_flags", {resp0_zero, resp0_less}, 32'd0);
        req0_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        step();

        // tie right after reset: req0 first, then req1, then req0 again
        req0_valid = 1'b1; req0_op = OP_ADD; req0_a = 32'd1;  req0_b = 32'd2;
        req1_valid = 1'b1; req1_op = OP_XOR; req1_a = 32'hFF; req1_b = 32'hFF;
        resp0_ready = 1'b1; resp1_ready = 1'b1;
        @(negedge clk);
        chk("tie1_r0_ready", req0_ready, 32'd1);
        chk("tie1_r1_ready", req1_ready, 32'd0);
        step();
        @(negedge clk);
        chk("tie1_exec_ready", {req1_ready, req0_ready}, 32'd0);
        chk("tie1_exec_a", alu_a, 32'd1);
        step();
        @(negedge clk);
        chk("tie1_rv0", resp0_valid, 32'd1);
        chk("tie1_rv1", resp1_valid, 32'd0);
        chk("tie1_res", resp0_result, 32'd3);
        chk("tie1_zero", resp0_zero, 32'd0);
        step();
        @(negedge clk);
        chk("tie2_r1_ready", req1_ready, 32'd1);
        chk("tie2_r0_ready", req0_ready, 32'd0);
        chk("tie2_park_op", alu_op, 32'd0);
        step();
        step();
        @(negedge clk);
        chk("tie2_rv1", resp1_valid, 32'd1);
        chk("tie2_rv0", resp0_valid, 32'd0);
        chk("tie2_res", resp1_result, 32'd0);
        chk("tie2_zero", resp1_zero, 32'd1);
        step();
        @(negedge clk);
        chk("tie3_r0_ready", req0_ready, 32'd1);
        chk("tie3_r1_ready", req1_ready, 32'd0);
        req0_valid = 1'b0; req1_valid = 1'b0;
        resp0_ready = 1'b0; resp1_ready = 1'b0;
        step();

        // table of single transactions
        for (int i = 0; i < 8; i++) begin
            run_txn(vecs[i], i);
        end

        // backpressure on resp1 while req0 waits
        req1_valid = 1'b1; req1_op = OP_SUB; req1_a = 32'd10; req1_b = 32'd3;
        resp1_ready = 1'b0; resp0_ready = 1'b1;
        @(negedge clk);
        chk("bp_r1_ready", req1_ready, 32'd1);
        step();
        req1_valid = 1'b0;
        req0_valid = 1'b1; req0_op = OP_ADD; req0_a = 32'd4; req0_b = 32'd4;
        @(negedge clk);
        chk("bp_exec_r0_ready", req0_ready, 32'd0);
        chk("bp_exec_busy", busy, 32'd1);
        step();
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk($sformatf("bp_hold%0d_rv1", i), resp1_valid, 32'd1);
            chk($sformatf("bp_hold%0d_res", i), resp1_result, 32'd7);
            chk($sformatf("bp_hold%0d_flags", i), {resp1_zero, resp1_less}, 32'd0);
            chk($sformatf("bp_hold%0d_r0_ready", i), req0_ready, 32'd0);
            chk($sformatf("bp_hold%0d_rv0", i), resp0_valid, 32'd0);
            step();
        end
        resp1_ready = 1'b1;
        step();
        resp1_ready = 1'b0;
        @(negedge clk);
        chk("bp_after_r0_ready", req0_ready, 32'd1);
        chk("bp_after_park_op", alu_op, 32'd0);
        chk("bp_after_park_a", alu_a, 32'd0);
        chk("bp_after_rv1", resp1_valid, 32'd0);
        step();
        req0_valid = 1'b0;
        @(negedge clk);
        chk("bp_r0_exec_a", alu_a, 32'd4);
        step();
        @(negedge clk);
        chk("bp_r0_rv0", resp0_valid, 32'd1);
        chk("bp_r0_res", resp0_result, 32'd8);
        chk("bp_r0_rv1", resp1_valid, 32'd0);
        step();
        resp0_ready = 1'b0;
        @(negedge clk);
        chk("bp_r0_done_busy", busy, 32'd0);
        step();

        // reset in the middle of EXEC
        req0_valid = 1'b1; req0_op = OP_SLL; req0_a = 32'd1; req0_b = 32'd4; resp0_ready = 1'b1;
        @(negedge clk);
        chk("mrst_accept", req0_ready, 32'd1);
        step();
        @(negedge clk);
        chk("mrst_in_exec", busy, 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("mrst_busy", busy, 32'd0);
        chk("mrst_r0_ready", req0_ready, 32'd0);
        chk("mrst_rv", {resp1_valid, resp0_valid}, 32'd0);
        chk("mrst_op", alu_op, 32'd0);
        chk("mrst_a", alu_a, 32'd0);
        chk("mrst_b", alu_b, 32'd0);
        chk("mrst_res", resp0_result, 32'd0);
        req0_valid = 1'b0;
        step();
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step();
            chk($sformatf("mrst_after%0d_rv0", i), resp0_valid, 32'd0);
            chk($sformatf("mrst_after%0d_busy", i), busy, 32'd0);
        end
        req0_valid = 1'b1; req1_valid = 1'b1;
        @(negedge clk);
        chk("mrst_tie_r0_ready", req0_ready, 32'd1);
        chk("mrst_tie_r1_ready", req1_ready, 32'd0);
        req0_valid = 1'b0; req1_valid = 1'b0; resp0_ready = 1'b0;
        step();
        step();

        chk("abort_count", abort_cnt, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
